// File: rtl/cheri_tbre_regs.sv
// MMIO register front-end for the background revocation engine (TBRE).
// Holds START/END/CTRL, hands a go pulse to the engine and tracks completion, duration and the interrupt.
module cheri_tbre_regs #(
    parameter int unsigned CycCntW  = 32,
    parameter logic [31:0] AddrMask = 32'hFFFF_FFF8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        reg_req_i,
    input  logic        reg_we_i,
    input  logic [4:0]  reg_addr_i,
    input  logic [31:0] reg_wdata_i,
    output logic [31:0] reg_rdata_o,
    output logic        reg_rvalid_o,
    output logic        reg_err_o,
    output logic [65:0] tbre_ctrl_vec_o,
    input  logic        tbre_stat_i,
    input  logic        tbre_err_i,
    output logic        tbre_irq_o
);

    localparam logic [2:0] OffStart  = 3'd0;
    localparam logic [2:0] OffEnd    = 3'd1;
    localparam logic [2:0] OffCtrl   = 3'd2;
    localparam logic [2:0] OffStatus = 3'd3;
    localparam logic [2:0] OffCycles = 3'd4;
    localparam logic [CycCntW-1:0] CntOne = 1;

    logic [31:0]        start_q, start_d;
    logic [31:0]        end_q, end_d;
    logic               go_q, go_d;
    logic               add1wait_q, add1wait_d;
    logic               irq_en_q, irq_en_d;
    logic               done_q, done_d;
    logic               err_at_done_q, err_at_done_d;
    logic               stat_q, stat_d;
    logic [CycCntW-1:0] cnt_q, cnt_d;
    logic               rvalid_q, rvalid_d;
    logic               err_q, err_d;
    logic [31:0]        rdata_q, rdata_d;

    logic        busy;
    logic        go_accept;
    logic        done_clr;
    logic        complete;
    logic [2:0]  sel;
    logic [31:0] cyc32;
    logic        unused_addr;

    assign unused_addr = ^reg_addr_i[1:0];
    assign sel         = reg_addr_i[4:2];
    assign busy        = go_q | tbre_stat_i;
    assign cyc32       = 32'(cnt_q);
    assign complete    = stat_q & ~tbre_stat_i;

    always_comb begin
        start_d       = start_q;
        end_d         = end_q;
        go_d          = go_q;
        add1wait_d    = add1wait_q;
        irq_en_d      = irq_en_q;
        done_d        = done_q;
        err_at_done_d = err_at_done_q;
        stat_d        = tbre_stat_i;
        cnt_d         = cnt_q;
        rvalid_d      = reg_req_i;
        err_d         = 1'b0;
        rdata_d       = 32'h0;
        go_accept     = 1'b0;
        done_clr      = 1'b0;

        if (reg_req_i) begin
            case (sel)
                OffStart: begin
                    if (!reg_we_i)  rdata_d = start_q;
                    else if (busy)  err_d   = 1'b1;
                    else            start_d = reg_wdata_i & AddrMask;
                end
                OffEnd: begin
                    if (!reg_we_i)  rdata_d = end_q;
                    else if (busy)  err_d   = 1'b1;
                    else            end_d   = reg_wdata_i & AddrMask;
                end
                OffCtrl: begin
                    if (!reg_we_i) begin
                        rdata_d = {29'h0, irq_en_q, add1wait_q, go_q};
                    end else if (reg_wdata_i[0] && busy) begin
                        err_d = 1'b1;
                    end else begin
                        // ADD1WAIT feeds the running engine, so a GO=0 write mid-walk only touches IRQ_EN
                        irq_en_d  = reg_wdata_i[2];
                        if (!busy) add1wait_d = reg_wdata_i[1];
                        go_accept = reg_wdata_i[0];
                    end
                end
                OffStatus: begin
                    if (reg_we_i) done_clr = reg_wdata_i[2];
                    else          rdata_d  = {28'h0, err_at_done_q, done_q, tbre_err_i, busy};
                end
                OffCycles: begin
                    if (!reg_we_i) rdata_d = cyc32;
                end
                default: err_d = 1'b1;
            endcase
        end

        if (tbre_stat_i) begin
            go_d = 1'b0;
            if (cnt_q != {CycCntW{1'b1}}) cnt_d = cnt_q + CntOne;
        end

        if (done_clr) done_d = 1'b0;
        if (complete) begin
            done_d        = 1'b1;
            err_at_done_d = tbre_err_i;
        end

        // A fresh walk discards the previous walk's completion record
        if (go_accept) begin
            go_d          = 1'b1;
            done_d        = 1'b0;
            err_at_done_d = 1'b0;
            cnt_d         = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            start_q       <= 32'h0;
            end_q         <= 32'h0;
            go_q          <= 1'b0;
            add1wait_q    <= 1'b0;
            irq_en_q      <= 1'b0;
            done_q        <= 1'b0;
            err_at_done_q <= 1'b0;
            stat_q        <= 1'b0;
            cnt_q         <= '0;
            rvalid_q      <= 1'b0;
            err_q         <= 1'b0;
            rdata_q       <= 32'h0;
        end else begin
            start_q       <= start_d;
            end_q         <= end_d;
            go_q          <= go_d;
            add1wait_q    <= add1wait_d;
            irq_en_q      <= irq_en_d;
            done_q        <= done_d;
            err_at_done_q <= err_at_done_d;
            stat_q        <= stat_d;
            cnt_q         <= cnt_d;
            rvalid_q      <= rvalid_d;
            err_q         <= err_d;
            rdata_q       <= rdata_d;
        end
    end

    assign reg_rdata_o     = rdata_q;
    assign reg_rvalid_o    = rvalid_q;
    assign reg_err_o       = err_q;
    assign tbre_ctrl_vec_o = {add1wait_q, go_q, end_q, start_q};
    assign tbre_irq_o      = done_q & irq_en_q;

endmodule

// File: doc/cheri_tbre_regs.md
Name: cheri_tbre_regs

Overview:
- MMIO register front-end for the background revocation engine (TBRE).
- Exposes start/end address, control and status registers on a simple register bus.
- Drives the engine's 66-bit control vector with a handshaked go, and watches its busy/error outputs.
- Provides a sticky completion flag, a walk-duration cycle counter and a level interrupt to the core.

Parameters:
- CycCntW, 32, width of the walk-duration counter (1..32); zero-extended into the 32-bit CYCLES readback.
- AddrMask, 32'hFFFF_FFF8, AND-mask applied to START/END writes (capability-aligned addresses).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- reg_req_i  in  1  register access strobe, single cycle, always accepted
- reg_we_i  in  1  1=write, 0=read
- reg_addr_i  in  5  byte offset; [1:0] ignored
- reg_wdata_i  in  32  write data
- reg_rdata_o  out  32  read data, valid when reg_rvalid_o=1
- reg_rvalid_o  out  1  read/write response, one cycle after reg_req_i
- reg_err_o  out  1  response error, qualified by reg_rvalid_o
- tbre_ctrl_vec_o  out  66  {add1wait[65], go[64], end_addr[63:32], start_addr[31:0]}
- tbre_stat_i  in  1  engine busy, 1 whenever the engine FSM is not idle
- tbre_err_i  in  1  engine latched error; cleared by the engine on go
- tbre_irq_o  out  1  level interrupt: done_q & irq_en_q

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset values: all registers and outputs 0, i.e. tbre_ctrl_vec_o=0, reg_rvalid_o=0, reg_err_o=0, tbre_irq_o=0, reg_rdata_o=0.
- Register map (offset: field):
  - 0x00 START: RW, stored as wdata & AddrMask.
  - 0x04 END: RW, stored as wdata & AddrMask.
  - 0x08 CTRL: bit0 GO (write 1 requests a walk; reads back go_q), bit1 ADD1WAIT RW, bit2 IRQ_EN RW.
  - 0x0C STATUS (RO except bit2): bit0 BUSY=go_q|tbre_stat_i, bit1 ERR=tbre_err_i, bit2 DONE (sticky, W1C), bit3 ERR_AT_DONE (snapshot).
  - 0x10 CYCLES: RO, counter value.
  - Any other offset: read returns 0 with reg_err_o=1; write is ignored with reg_err_o=1.
- Bus timing: every reg_req_i gets reg_rvalid_o=1 exactly one cycle later. reg_rdata_o is registered and is 0 for writes. Writes take effect at the clock edge where reg_req_i=1.
- Busy protection: a write to START, END, or CTRL with GO=1 while BUSY=1 is dropped entirely, including the ADD1WAIT/IRQ_EN bits, and returns reg_err_o=1. A CTRL write with GO=0 is always accepted.
- Go handshake:
  - An accepted GO write sets go_q; tbre_ctrl_vec_o[64]=go_q.
  - go_q clears on the first cycle tbre_stat_i=1.
  - go_q is never cleared by software.
  - START, END and ADD1WAIT are stable while go_q=1 or tbre_stat_i=1.
- Go acceptance side effects: clear DONE and ERR_AT_DONE, and clear the counter to 0.
- No start/end ordering check: END<START is passed through as-is.
- Completion:
  - stat_q registers tbre_stat_i.
  - stat_q=1 & tbre_stat_i=0 sets done_q and captures ERR_AT_DONE=tbre_err_i.
  - Completion set and DONE W1C in the same cycle: set wins.
- Cycle counter: increments every cycle with tbre_stat_i=1 and saturates at all-ones (no wrap). It holds its value when idle.
- Interrupt: tbre_irq_o is combinational from flops, with no glitch paths from bus inputs. Setting IRQ_EN while DONE=1 asserts it the next cycle.
- Reset mid-walk: the block returns to reset values immediately. The engine has its own reset; no recovery handshake is performed.

Test Plan:
- Write START=0x2000_0004, END=0x2000_00FF, then GO=1 -> tbre_ctrl_vec_o[31:0]=0x2000_0000, [63:32]=0x2000_00F8; go high until the tbre_stat_i rising edge, then low; STATUS.BUSY=1 throughout.
- Model tbre_stat_i high for 37 cycles then low, with IRQ_EN=1 -> CYCLES reads 37, DONE=1, tbre_irq_o=1 from the cycle after the falling edge; write STATUS=0x4 -> irq deasserts next cycle.
- While busy, write START=0x1234_0000 and CTRL=0x1 -> both reg_err_o=1; START unchanged; no second go pulse.
- tbre_err_i=1 at the falling edge of tbre_stat_i -> ERR_AT_DONE=1; a new GO clears it and DONE.
- Read offsets 0x14 and 0x1C -> rdata=0, reg_err_o=1; write 0x18 -> no state change, reg_err_o=1.
- Assert rst_i mid-walk with go_q=1 and DONE=1 -> all outputs 0 asynchronously; with CycCntW=4 and a 20-cycle walk, CYCLES saturates at 15.
